// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler
// Game phase sequencer for whac-a-mole: derives a 1 ms tick from the system
// clock, counts down the overall game time, and alternates mole-down and
// mole-up phases. A spawn pulse tells the mole generator to load new
// positions at the start of every up-window. The up-window shrinks as the
// level rises, down to a floor.

module mole_round_scheduler #(
    parameter int CLKS_PER_MS      = 50000,
    parameter int GAME_MS          = 20000,
    parameter int MOLE_UP_MS       = 1000,
    parameter int MOLE_DOWN_MS     = 500,
    parameter int MIN_UP_MS        = 300,
    parameter int STEP_MS          = 100,
    parameter int ROUNDS_PER_LEVEL = 5,
    parameter int MAX_LEVEL        = 7
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               all_hit,
    output logic                               spawn,
    output logic                               mole_up_window,
    output logic                               game_in_progress,
    output logic                               game_over,
    output logic [$clog2(GAME_MS+1)-1:0]       time_left_ms,
    output logic [$clog2(MAX_LEVEL+1)-1:0]     level,
    output logic [7:0]                         round_count
);

    localparam int TIME_W    = $clog2(GAME_MS + 1);
    localparam int LEVEL_W   = $clog2(MAX_LEVEL + 1);
    localparam int PRE_W     = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int PHASE_M1  = (MOLE_UP_MS > MOLE_DOWN_MS) ? MOLE_UP_MS : MOLE_DOWN_MS;
    localparam int PHASE_MAX = (PHASE_M1 > MIN_UP_MS) ? PHASE_M1 : MIN_UP_MS;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [PHASE_W-1:0] PHASE_DOWN = PHASE_W'(MOLE_DOWN_MS);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [TIME_W-1:0]  TIME_FULL  = TIME_W'(GAME_MS);
    localparam logic [TIME_W-1:0]  TIME_ONE   = TIME_W'(1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
    localparam logic [31:0]        STEP_U     = 32'(STEP_MS);
    localparam logic [31:0]        MIN_UP_U   = 32'(MIN_UP_MS);
    localparam logic [31:0]        MOLE_UP_U  = 32'(MOLE_UP_MS);
    localparam logic [31:0]        RPL_U      = 32'(ROUNDS_PER_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_UP   = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    state_t               state_r, state_s;
    logic [PRE_W-1:0]     pre_r, pre_s;
    logic [PHASE_W-1:0]   phase_r, phase_s;
    logic [TIME_W-1:0]    time_r, time_s;
    logic [LEVEL_W-1:0]   level_r, level_s;
    logic [7:0]           round_r, round_s;
    logic                 spawn_r, spawn_s;

    logic                 running_s;
    logic                 ms_tick_s;
    logic                 phase_end_s;
    logic                 time_end_s;
    logic [7:0]           round_inc_s;
    logic                 level_bump_s;

    // Up-window length for a level; the comparison is arranged so that the
    // subtraction only happens when it cannot go below the floor.
    function automatic logic [PHASE_W-1:0] up_len_f(input logic [LEVEL_W-1:0] lvl);
        logic [31:0] cut;
        cut = 32'(lvl) * STEP_U;
        if ((cut + MIN_UP_U) >= MOLE_UP_U) begin
            up_len_f = PHASE_W'(MIN_UP_U);
        end else begin
            up_len_f = PHASE_W'(MOLE_UP_U - cut);
        end
    endfunction

    // Tick and end-of-phase/end-of-game qualifiers plus round/level bookkeeping.
    always_comb begin
        running_s    = (state_r == ST_DOWN) || (state_r == ST_UP);
        ms_tick_s    = running_s && (pre_r == PRE_LAST);
        phase_end_s  = ms_tick_s && (phase_r == PHASE_ONE);
        time_end_s   = ms_tick_s && (time_r == TIME_ONE);
        round_inc_s  = (round_r == 8'hFF) ? round_r : (round_r + 8'd1);
        level_bump_s = (round_r != 8'hFF) && ((({24'd0, round_inc_s}) % RPL_U) == 32'd0);
    end

    // Next-state and datapath update; game-over outranks any phase change.
    always_comb begin
        state_s = state_r;
        pre_s   = pre_r;
        phase_s = phase_r;
        time_s  = time_r;
        level_s = level_r;
        round_s = round_r;
        spawn_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_s = ST_DOWN;
                    pre_s   = '0;
                    phase_s = PHASE_DOWN;
                    time_s  = TIME_FULL;
                    level_s = '0;
                    round_s = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DOWN, ST_UP: begin
                if (ms_tick_s) begin
                    pre_s   = '0;
                    phase_s = (phase_r == '0) ? phase_r : (phase_r - PHASE_ONE);
                    time_s  = (time_r == '0) ? time_r : (time_r - TIME_ONE);
                end else begin
                    pre_s   = pre_r + PRE_W'(1);
                end
                if (time_end_s) begin
                    state_s = ST_OVER;
                    time_s  = '0;
                end else if ((state_r == ST_DOWN) && phase_end_s) begin
                    state_s = ST_UP;
                    phase_s = up_len_f(level_r);
                    spawn_s = 1'b1;
                end else if ((state_r == ST_UP) && (phase_end_s || all_hit)) begin
                    state_s = ST_DOWN;
                    phase_s = PHASE_DOWN;
                    round_s = round_inc_s;
                    if (level_bump_s && (level_r != LEVEL_MAX)) begin
                        level_s = level_r + LEVEL_ONE;
                    end else begin
                        level_s = level_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset returns to IDLE with all outputs low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pre_r   <= '0;
            phase_r <= '0;
            time_r  <= '0;
            level_r <= '0;
            round_r <= 8'd0;
            spawn_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pre_r   <= pre_s;
            phase_r <= phase_s;
            time_r  <= time_s;
            level_r <= level_s;
            round_r <= round_s;
            spawn_r <= spawn_s;
        end
    end

    assign spawn            = spawn_r;
    assign mole_up_window   = (state_r == ST_UP);
    assign game_in_progress = (state_r == ST_DOWN) || (state_r == ST_UP);
    assign game_over        = (state_r == ST_OVER);
    assign time_left_ms     = time_r;
    assign level            = level_r;
    assign round_count      = round_r;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler with a cycle-indexed scoreboard.
// Cycle c is the clock period following the c-th rising edge after the game
// start; an input held during cycle c is sampled at the edge that begins c+1.
module tb_mole_round_scheduler;

    localparam int CLKS_PER_MS      = 5;
    localparam int GAME_MS          = 60;
    localparam int MOLE_UP_MS       = 5;
    localparam int MOLE_DOWN_MS     = 5;
    localparam int MIN_UP_MS        = 2;
    localparam int STEP_MS          = 1;
    localparam int ROUNDS_PER_LEVEL = 2;
    localparam int MAX_LEVEL        = 7;
    localparam int TW = $clog2(GAME_MS + 1);
    localparam int LW = $clog2(MAX_LEVEL + 1);

    localparam int S_SPAWN = 0;
    localparam int S_UP    = 1;
    localparam int S_RUN   = 2;
    localparam int S_OVER  = 3;
    localparam int S_TIME  = 4;
    localparam int S_LEVEL = 5;
    localparam int S_ROUND = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          all_hit;
    logic          spawn;
    logic          mole_up_window;
    logic          game_in_progress;
    logic          game_over;
    logic [TW-1:0] time_left_ms;
    logic [LW-1:0] level;
    logic [7:0]    round_count;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   errors = 0;
    int   checks = 0;
    int   spawn_seen;

    always #5 clk = ~clk;

    mole_round_scheduler #(
        .CLKS_PER_MS      (CLKS_PER_MS),
        .GAME_MS          (GAME_MS),
        .MOLE_UP_MS       (MOLE_UP_MS),
        .MOLE_DOWN_MS     (MOLE_DOWN_MS),
        .MIN_UP_MS        (MIN_UP_MS),
        .STEP_MS          (STEP_MS),
        .ROUNDS_PER_LEVEL (ROUNDS_PER_LEVEL),
        .MAX_LEVEL        (MAX_LEVEL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .all_hit          (all_hit),
        .spawn            (spawn),
        .mole_up_window   (mole_up_window),
        .game_in_progress (game_in_progress),
        .game_over        (game_over),
        .time_left_ms     (time_left_ms),
        .level            (level),
        .round_count      (round_count)
    );

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_SPAWN: obs = {31'd0, spawn};
            S_UP:    obs = {31'd0, mole_up_window};
            S_RUN:   obs = {31'd0, game_in_progress};
            S_OVER:  obs = {31'd0, game_over};
            S_TIME:  obs = 32'(time_left_ms);
            S_LEVEL: obs = 32'(level);
            S_ROUND: obs = 32'(round_count);
            default: obs = 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic expect_at(input int c, input int sel, input int val, input string tag);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (spawn === 1'b1) spawn_seen++;
        while ((sb.size() > 0) && (sb[0].cyc <= cyc)) begin
            e = sb.pop_front();
            chk($sformatf("%s@%0d", e.tag, e.cyc), obs(e.sel), e.val);
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_start(input int c);
        run_to(c);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_hit(input int c);
        run_to(c);
        all_hit = 1'b1;
        tick();
        all_hit = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        all_hit    = 1'b0;
        cyc        = 0;
        spawn_seen = 0;
        repeat (3) @(negedge clk);
        chk("rst_spawn", obs(S_SPAWN), 0);
        chk("rst_run",   obs(S_RUN),   0);
        chk("rst_over",  obs(S_OVER),  0);
        chk("rst_time",  obs(S_TIME),  0);
        reset = 1'b0;

        // all_hit while idle must do nothing
        @(negedge clk);
        all_hit = 1'b1;
        @(negedge clk);
        all_hit = 1'b0;
        @(negedge clk);
        chk("idle_hit_run",   obs(S_RUN),   0);
        chk("idle_hit_round", obs(S_ROUND), 0);
        chk("idle_hit_spawn", obs(S_SPAWN), 0);

        // ---- game 1: expected timeline ----
        expect_at(1,   S_RUN,   1,  "down_entry");
        expect_at(1,   S_TIME,  60, "time_load");
        expect_at(1,   S_LEVEL, 0,  "level_init");
        expect_at(1,   S_UP,    0,  "down_not_up");
        expect_at(25,  S_UP,    0,  "down_len");
        expect_at(26,  S_SPAWN, 1,  "spawn1");
        expect_at(26,  S_UP,    1,  "up1");
        expect_at(27,  S_SPAWN, 0,  "spawn1_pulse");
        expect_at(50,  S_UP,    1,  "up_l0_len");
        expect_at(51,  S_UP,    0,  "up_l0_end");
        expect_at(51,  S_ROUND, 1,  "round1");
        expect_at(61,  S_UP,    0,  "down_hit_up");
        expect_at(61,  S_RUN,   1,  "down_hit_run");
        expect_at(61,  S_ROUND, 1,  "down_hit_round");
        expect_at(75,  S_UP,    0,  "down2_len");
        expect_at(76,  S_SPAWN, 1,  "spawn2");
        expect_at(100, S_UP,    1,  "up2_len");
        expect_at(101, S_ROUND, 2,  "round2");
        expect_at(101, S_LEVEL, 1,  "level1");
        expect_at(126, S_SPAWN, 1,  "spawn3");
        expect_at(131, S_UP,    1,  "start_in_up");
        expect_at(131, S_TIME,  34, "start_in_up_time");
        expect_at(131, S_ROUND, 2,  "start_in_up_round");
        expect_at(145, S_UP,    1,  "up_l1_len");
        expect_at(146, S_UP,    0,  "up_l1_end");
        expect_at(146, S_ROUND, 3,  "round3");
        expect_at(171, S_SPAWN, 1,  "spawn4");
        expect_at(175, S_UP,    0,  "hit_mid_up");
        expect_at(175, S_ROUND, 4,  "round4");
        expect_at(175, S_LEVEL, 2,  "level2");
        expect_at(195, S_UP,    0,  "down_aligned");
        expect_at(196, S_SPAWN, 1,  "spawn5");
        expect_at(197, S_UP,    0,  "hit_at_spawn");
        expect_at(197, S_ROUND, 5,  "round5");
        expect_at(221, S_SPAWN, 1,  "spawn6");
        expect_at(233, S_ROUND, 6,  "round6");
        expect_at(233, S_LEVEL, 3,  "level3");
        expect_at(255, S_UP,    0,  "down_before7");
        expect_at(256, S_SPAWN, 1,  "spawn7");
        expect_at(265, S_UP,    1,  "clamp_len");
        expect_at(266, S_UP,    0,  "clamp_end");
        expect_at(266, S_ROUND, 7,  "round7");
        expect_at(291, S_SPAWN, 1,  "spawn8");
        expect_at(296, S_TIME,  1,  "time_last");
        expect_at(300, S_UP,    1,  "up_at_timeout");
        expect_at(301, S_OVER,  1,  "over");
        expect_at(301, S_RUN,   0,  "over_run");
        expect_at(301, S_TIME,  0,  "over_time");
        expect_at(301, S_SPAWN, 0,  "over_spawn");
        expect_at(301, S_UP,    0,  "over_up");
        expect_at(301, S_ROUND, 7,  "over_round");
        expect_at(301, S_LEVEL, 3,  "over_level");
        expect_at(305, S_OVER,  1,  "over_hold");
        expect_at(305, S_TIME,  0,  "over_hold_time");

        cyc        = 0;
        spawn_seen = 0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        pulse_hit(60);
        pulse_start(130);
        pulse_hit(174);
        pulse_hit(196);
        pulse_hit(232);
        pulse_hit(300);
        run_to(305);
        chk("spawn_count", spawn_seen, 8);

        // ---- game 2: restart from OVER, then reset mid-UP ----
        expect_at(306, S_RUN,   1,  "restart_run");
        expect_at(306, S_OVER,  0,  "restart_over");
        expect_at(306, S_LEVEL, 0,  "restart_level");
        expect_at(306, S_ROUND, 0,  "restart_round");
        expect_at(306, S_TIME,  60, "restart_time");
        expect_at(330, S_UP,    0,  "restart_down_len");
        expect_at(331, S_SPAWN, 1,  "restart_spawn");
        expect_at(331, S_UP,    1,  "restart_up");
        pulse_start(305);
        run_to(333);

        #2 reset = 1'b1;
        #1;
        chk("arst_spawn", obs(S_SPAWN), 0);
        chk("arst_up",    obs(S_UP),    0);
        chk("arst_run",   obs(S_RUN),   0);
        chk("arst_time",  obs(S_TIME),  0);
        chk("arst_level", obs(S_LEVEL), 0);
        chk("arst_round", obs(S_ROUND), 0);
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b0;
        spawn_seen = 0;
        repeat (40) tick();
        chk("post_rst_spawns", spawn_seen, 0);
        chk("post_rst_run",    obs(S_RUN), 0);

        // start in the very first clock after reset release is accepted
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("first_clk_start_run",  obs(S_RUN),  1);
        chk("first_clk_start_time", obs(S_TIME), 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mole_round_scheduler.md
# mole_round_scheduler

Sequences the whac-a-mole game. It derives a millisecond tick from the system clock, runs the overall game countdown, and alternates mole-down and mole-up phases. It pulses the mole generator at the start of each up-window and shortens the up-window as the level rises. It sits between the debounced start key and the mole generator, hit detector and timer display, and takes over phase sequencing from the top-level game FSM.

## Interface
- CLKS_PER_MS, 50000, clock cycles per millisecond tick
- GAME_MS, 20000, game length in ms
- MOLE_UP_MS, 1000, up-window length at level 0
- MOLE_DOWN_MS, 500, down-phase length (constant)
- MIN_UP_MS, 300, floor on up-window length
- STEP_MS, 100, up-window reduction per level
- ROUNDS_PER_LEVEL, 5, completed rounds per level increment
- MAX_LEVEL, 7, level saturation value
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high; one clock, all state clears immediately
- start  in  1  debounced single-cycle start pulse
- all_hit  in  1  every mole of the current round has been hit; honoured only in UP
- spawn  out  1  single-cycle pulse: mole generator loads new positions
- mole_up_window  out  1  high while in UP
- game_in_progress  out  1  high in DOWN or UP
- game_over  out  1  high in OVER
- time_left_ms  out  $clog2(GAME_MS+1)  remaining game time
- level  out  $clog2(MAX_LEVEL+1)  current difficulty level
- round_count  out  8  completed rounds, saturates at 255

## Operation
- States: IDLE, DOWN, UP, OVER. Reset puts the block in IDLE with every output 0.
- Prescaler counts 0..CLKS_PER_MS-1. ms_tick is asserted on the terminal count.
- Prescaler runs only in DOWN and UP. It is cleared on start acceptance, so the first ms is full length.
- start in IDLE or OVER:
  - next state DOWN
  - time_left_ms loaded with GAME_MS
  - level and round_count cleared to 0
  - phase counter loaded with MOLE_DOWN_MS
- start in DOWN or UP is ignored.
- Phase counter decrements on ms_tick. A tick with phase counter == 1 ends the phase.
- DOWN end:
  - next state UP; spawn is high for that first UP cycle
  - phase counter loaded with up_len
  - up_len = MIN_UP_MS if level*STEP_MS >= MOLE_UP_MS-MIN_UP_MS, else MOLE_UP_MS-level*STEP_MS
  - compute up_len without unsigned underflow
- UP end (phase expiry, or all_hit high in UP):
  - next state DOWN; phase counter loaded with MOLE_DOWN_MS
  - round_count increments
  - if the new round_count is a multiple of ROUNDS_PER_LEVEL, level increments, saturating at MAX_LEVEL
- all_hit in IDLE, DOWN or OVER has no effect.
- Game timer:
  - time_left_ms decrements on each ms_tick in DOWN or UP, never below 0
  - a tick that takes it from 1 to 0 sends the state to OVER
  - OVER has priority over any simultaneous phase end or all_hit: no spawn, no round or level increment
- OVER holds time_left_ms = 0 and keeps level and round_count for display.

## Timing
- start sampled high at cycle N: DOWN from N+1, first spawn at cycle N+1+MOLE_DOWN_MS*CLKS_PER_MS.
- DOWN lasts exactly MOLE_DOWN_MS*CLKS_PER_MS cycles. A full UP lasts exactly up_len*CLKS_PER_MS cycles.
- all_hit sampled high in UP at cycle M: DOWN at M+1. all_hit at the spawn cycle itself is honoured.
- The prescaler is not cleared between phases; phase boundaries stay aligned to ms_tick.
- Outputs are registered or decoded from the state register only. No combinational path from start or all_hit to any output.
- reset mid-game: outputs 0 asynchronously; IDLE on the first clock after release. A start in that first clock is accepted.

## Test plan
- Params CLKS_PER_MS=5, MOLE_DOWN_MS=5, MOLE_UP_MS=5, STEP_MS=1, MIN_UP_MS=2, ROUNDS_PER_LEVEL=2, MAX_LEVEL=7, GAME_MS=60.
- start at cycle 0 -> DOWN at cycle 1, time_left_ms=60; spawn and mole_up_window rise at cycle 26; UP at level 0 lasts 25 cycles; round_count=1 at cycle 51.
- After 2 full rounds -> level=1, next UP lasts 20 cycles. Force all_hit on each spawn cycle -> levels 3 and above give 10-cycle UP windows (clamp). Level holds at 7.
- all_hit pulsed in DOWN and in IDLE -> no state, round or level change. all_hit 3 cycles into UP -> DOWN on the next cycle, round_count+1.
- Run to timeout -> OVER at cycle 301: game_over=1, game_in_progress=0, time_left_ms=0, no spawn. Arrange a phase end on the same tick -> round_count unchanged.
- start during UP -> ignored. start in OVER -> DOWN next cycle, level=0, round_count=0, time_left_ms=60.
- reset asserted mid-UP -> every output 0 immediately. After release, no spawn until a new start.
